// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destination registers after decode,
// selects forwarding sources, raises load-use / interlock stalls and freezes
// fetch after taken control transfers (branch freeze, one-cycle jump flush).
//
// Handshake: this block has no valid/ready pair; an instruction in decode
// "issues" in a cycle when DecValid=1, StallD=0 and FlushD=0, and it is then
// captured into tracked stage 1 on the next rising edge.
module pipe_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int BR_PENALTY = 3,
  parameter int FWD_EN     = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              DecValid,
  input  logic [REG_AW-1:0] DecRs,
  input  logic [REG_AW-1:0] DecRt,
  input  logic              DecUsesRs,
  input  logic              DecUsesRt,
  input  logic              DecWrEn,
  input  logic [REG_AW-1:0] DecWrAddr,
  input  logic              DecIsLoad,
  input  logic              DecIsBranch,
  input  logic              DecIsJump,
  output logic              StallF,
  output logic              StallD,
  output logic              BubbleE,
  output logic              FlushD,
  output logic [2:0]        FwdA,
  output logic [2:0]        FwdB,
  output logic [15:0]       StallCount,
  output logic [1:0]        DbgState,
  output logic [REG_AW+1:0] DbgWb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FREEZE = 2'd1,
    JUMP   = 2'd2
  } br_state_t;

  br_state_t         state, state_nxt;
  logic [3:0]        frz_cnt, frz_cnt_nxt;

  logic [DEPTH:1]    sb_valid;
  logic [DEPTH:1]    sb_load;
  logic [REG_AW-1:0] sb_addr [1:DEPTH];

  logic [DEPTH-1:1]  hit_a, hit_b;
  logic              hazard;
  logic              data_stall;
  logic              issue;

  // Source matches against forwardable stages; r0 and unused sources never match
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= DEPTH-1; k++) begin
      hit_a[k] = sb_valid[k] && (sb_addr[k] == DecRs) && DecUsesRs && (DecRs != '0);
      hit_b[k] = sb_valid[k] && (sb_addr[k] == DecRt) && DecUsesRt && (DecRt != '0);
    end
  end

  // Forward selection (youngest wins) and hazard detection
  always_comb begin
    FwdA   = '0;
    FwdB   = '0;
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (hit_a[k]) FwdA = 3'(k);
        if (hit_b[k]) FwdB = 3'(k);
      end
      hazard = (hit_a[1] || hit_b[1]) && sb_load[1];
    end else begin
      hazard = (|hit_a) || (|hit_b);
    end
  end

  // Pipeline control; a wrong-path decode slot (freeze/jump flush) never stalls
  always_comb begin
    data_stall = DecValid && hazard && (state == IDLE);
    StallD     = data_stall;
    BubbleE    = data_stall;
    StallF     = data_stall || (state == FREEZE);
    FlushD     = (state != IDLE);
    issue      = DecValid && !StallD && !FlushD;
    DbgState   = state;
    DbgWb      = {sb_valid[DEPTH], sb_load[DEPTH], sb_addr[DEPTH]};
  end

  // Branch/jump FSM next state
  always_comb begin
    state_nxt   = state;
    frz_cnt_nxt = frz_cnt;
    case (state)
      IDLE: begin
        if (issue && DecIsBranch && (BR_PENALTY > 0)) begin
          state_nxt   = FREEZE;
          frz_cnt_nxt = 4'(BR_PENALTY);
        end else if (issue && DecIsJump) begin
          state_nxt = JUMP;
        end
      end
      FREEZE: begin
        if (frz_cnt <= 4'd1) begin
          state_nxt   = IDLE;
          frz_cnt_nxt = 4'd0;
        end else begin
          frz_cnt_nxt = frz_cnt - 4'd1;
        end
      end
      JUMP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      frz_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      frz_cnt <= frz_cnt_nxt;
    end
  end

  // Scoreboard shift register; advances every cycle, bubble when nothing issues
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sb_valid <= '0;
      sb_load  <= '0;
      for (int k = 1; k <= DEPTH; k++) sb_addr[k] <= '0;
    end else begin
      sb_valid[1] <= issue && DecWrEn && (DecWrAddr != '0);
      sb_load[1]  <= issue && DecIsLoad;
      sb_addr[1]  <= DecWrAddr;
      for (int k = 2; k <= DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_load[k]  <= sb_load[k-1];
        sb_addr[k]  <= sb_addr[k-1];
      end
    end
  end

  // Saturating count of decode-stall cycles
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCount <= 16'd0;
    end else if (StallD && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule
